// File: rtl/super_writeback_if.sv
// -----------------------------------------------------------------------------
// super_writeback_if
//   Bundle between the memory stage and the write-back stage, plus the
//   write-back results returned to the decoder register files and fetch.
//
//   Memory-stage side (driven by master, consumed by slave):
//     res_i, writeResultInt_i, writeResultV_i, intRegDest_i, vecRegDest_i,
//     enableJump_i, jumpAddress_i, flagEnd_i, flagNop_i
//   Write-back side (driven by slave):
//     int_we_o/int_dest_o/int_wd_o   integer register file write port
//     vec_we_o/vec_dest_o/vec_wd_o   vector register file write port
//     pc_sel_o/redirect_pc_o         PC redirect towards fetch
//     flush_o, halt_o                squash indicator, sticky halt
//     retired_cnt_o                  only when WB_RETIRE_CNT_EN is defined
// -----------------------------------------------------------------------------
interface super_writeback_if #(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int REGI_SIZE = 16,
  parameter int VECT_SIZE = 8,
  parameter int ELEM_SIZE = 8
);
  logic [ELEM_SIZE*VECT_SIZE-1:0] res_i;
  logic                           writeResultInt_i;
  logic                           writeResultV_i;
  logic [REGI_BITS-1:0]           intRegDest_i;
  logic [VECT_BITS-1:0]           vecRegDest_i;
  logic                           enableJump_i;
  logic [9:0]                     jumpAddress_i;
  logic                           flagEnd_i;
  logic                           flagNop_i;

  logic                           int_we_o;
  logic [REGI_BITS-1:0]           int_dest_o;
  logic [REGI_SIZE-1:0]           int_wd_o;
  logic                           vec_we_o;
  logic [VECT_BITS-1:0]           vec_dest_o;
  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_wd_o;
  logic                           pc_sel_o;
  logic [REGI_SIZE-1:0]           redirect_pc_o;
  logic                           flush_o;
  logic                           halt_o;
`ifdef WB_RETIRE_CNT_EN
  logic [REGI_SIZE-1:0]           retired_cnt_o;
`endif

  modport master (
`ifdef WB_RETIRE_CNT_EN
    input  retired_cnt_o,
`endif
    output res_i, writeResultInt_i, writeResultV_i, intRegDest_i, vecRegDest_i,
           enableJump_i, jumpAddress_i, flagEnd_i, flagNop_i,
    input  int_we_o, int_dest_o, int_wd_o, vec_we_o, vec_dest_o, vec_wd_o,
           pc_sel_o, redirect_pc_o, flush_o, halt_o
  );

  modport slave (
`ifdef WB_RETIRE_CNT_EN
    output retired_cnt_o,
`endif
    input  res_i, writeResultInt_i, writeResultV_i, intRegDest_i, vecRegDest_i,
           enableJump_i, jumpAddress_i, flagEnd_i, flagNop_i,
    output int_we_o, int_dest_o, int_wd_o, vec_we_o, vec_dest_o, vec_wd_o,
           pc_sel_o, redirect_pc_o, flush_o, halt_o
  );
endinterface

// File: rtl/super_writeback.sv
// -----------------------------------------------------------------------------
// super_writeback
//   Write-back stage of the vector pipeline. Turns memory-stage results into
//   register-file write ports, redirects fetch on taken jumps, squashes the
//   FLUSH_DEPTH younger wrong-path instructions behind a jump and latches the
//   END instruction into a sticky halt. All outputs are registered.
//
//   Ports:
//     clk_i   clock, rising edge
//     rst_i   asynchronous, active-low reset
//     wb      super_writeback_if.slave (memory-stage inputs, write-back outputs)
//
//   Optional feature (macro WB_RETIRE_CNT_EN): wb.retired_cnt_o counts live
//   (retired) instructions, wraps at 2**REGI_SIZE and freezes in HALT.
// -----------------------------------------------------------------------------
module super_writeback #(
  parameter int REGI_BITS   = 4,
  parameter int VECT_BITS   = 2,
  parameter int REGI_SIZE   = 16,
  parameter int VECT_SIZE   = 8,
  parameter int ELEM_SIZE   = 8,
  parameter int FLUSH_DEPTH = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  super_writeback_if.slave wb
);

  localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH + 1) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    HALT  = 2'b10
  } wbState_e;

  wbState_e         stateQ, stateD;
  logic [CNT_W-1:0] flushCntQ, flushCntD;
  logic             isLive;
  logic             intWeD, vecWeD, pcSelD;

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    stateD    = stateQ;
    flushCntD = flushCntQ;
    isLive    = 1'b0;
    intWeD    = 1'b0;
    vecWeD    = 1'b0;
    pcSelD    = 1'b0;
    case (stateQ)
      RUN: begin
        isLive = !wb.flagNop_i && !wb.flagEnd_i;
        intWeD = isLive && wb.writeResultInt_i;
        vecWeD = isLive && wb.writeResultV_i;
        // END takes priority over a jump in the same instruction.
        if (wb.flagEnd_i) begin
          stateD = HALT;
        end else if (wb.enableJump_i) begin
          pcSelD = 1'b1;
          if (FLUSH_DEPTH > 0) begin
            stateD    = FLUSH;
            flushCntD = CNT_W'(FLUSH_DEPTH);
          end
        end
      end
      FLUSH: begin
        // Each input cycle here is a wrong-path instruction; the last one
        // (counter at 1) hands control back to RUN.
        if (flushCntQ <= CNT_W'(1)) begin
          stateD = RUN;
        end else begin
          flushCntD = flushCntQ - CNT_W'(1);
        end
      end
      HALT:    stateD = HALT;
      default: stateD = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stateQ           <= RUN;
      flushCntQ        <= '0;
      wb.int_we_o      <= 1'b0;
      wb.int_dest_o    <= '0;
      wb.int_wd_o      <= '0;
      wb.vec_we_o      <= 1'b0;
      wb.vec_dest_o    <= '0;
      wb.vec_wd_o      <= '0;
      wb.pc_sel_o      <= 1'b0;
      wb.redirect_pc_o <= '0;
    end else begin
      stateQ        <= stateD;
      flushCntQ     <= flushCntD;
      wb.int_we_o   <= intWeD;
      wb.int_dest_o <= wb.intRegDest_i;
      wb.int_wd_o   <= wb.res_i[REGI_SIZE-1:0];
      wb.vec_we_o   <= vecWeD;
      wb.vec_dest_o <= wb.vecRegDest_i;
      wb.vec_wd_o   <= wb.res_i;
      wb.pc_sel_o   <= pcSelD;
      // The redirect target is held between jumps so fetch can re-read it.
      if (pcSelD) begin
        wb.redirect_pc_o <= {{(REGI_SIZE-10){1'b0}}, wb.jumpAddress_i};
      end
    end
  end

  // Decoded straight from the state flops, so both clear with the async reset.
  assign wb.flush_o = (stateQ == FLUSH);
  assign wb.halt_o  = (stateQ == HALT);

`ifdef WB_RETIRE_CNT_EN
  // isLive is only ever set in RUN, which also freezes the count in HALT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb.retired_cnt_o <= '0;
    end else if (isLive) begin
      wb.retired_cnt_o <= wb.retired_cnt_o + REGI_SIZE'(1);
    end
  end
`endif

endmodule

// File: doc/super_writeback.md
Name: super_writeback

Overview:
- Final (write-back) stage of the vector processor pipeline, downstream of the memory stage.
- Consumes memory-stage results and produces write ports for the integer and vector register files inside the decoder.
- Drives the PC redirect back to the fetch stage on taken jumps.
- Squashes wrong-path instructions after a jump and latches program end into a halt.

Parameters:
- REGI_BITS, 4, integer register index width
- VECT_BITS, 2, vector register index width
- REGI_SIZE, 16, integer register / PC width
- VECT_SIZE, 8, elements per vector
- ELEM_SIZE, 8, bits per element
- FLUSH_DEPTH, 3, number of younger in-flight instructions squashed after a taken jump (fetch..memory)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- res_i  in  ELEM_SIZE*VECT_SIZE  result from memory stage (memory read data or ALU result)
- writeResultInt_i  in  1  instruction writes integer register
- writeResultV_i  in  1  instruction writes vector register
- intRegDest_i  in  REGI_BITS  integer destination
- vecRegDest_i  in  VECT_BITS  vector destination
- enableJump_i  in  1  taken jump resolved
- jumpAddress_i  in  10  jump target
- flagEnd_i  in  1  END instruction
- flagNop_i  in  1  NOP / bubble
- int_we_o  out  1  integer register file write enable
- int_dest_o  out  REGI_BITS  integer write index
- int_wd_o  out  REGI_SIZE  integer write data
- vec_we_o  out  1  vector register file write enable
- vec_dest_o  out  VECT_BITS  vector write index
- vec_wd_o  out  ELEM_SIZE*VECT_SIZE  vector write data
- pc_sel_o  out  1  select redirect PC in fetch
- redirect_pc_o  out  REGI_SIZE  redirect target
- flush_o  out  1  high while squashing
- halt_o  out  1  program ended, sticky

Behaviour:
- All outputs are registered with 1-cycle latency from the inputs. On reset every output is 0 and the state is RUN.
- Write data:
  - int_wd_o = res_i[REGI_SIZE-1:0].
  - vec_wd_o = res_i.
  - Indices pass through unchanged.
- An instruction is live when state==RUN, flagNop_i==0 and flagEnd_i==0.
  - Live with writeResultInt_i: int_we_o=1 for one cycle.
  - Live with writeResultV_i: vec_we_o=1 for one cycle.
  - Both flags set: both write enables assert in the same cycle.
- Taken jump:
  - Condition: enableJump_i in RUN and not flagEnd_i.
  - Next cycle: pc_sel_o=1 for exactly one cycle; redirect_pc_o = {6'b0, jumpAddress_i}, held until the next redirect or reset.
  - State goes to FLUSH with the counter loaded to FLUSH_DEPTH. The jump's own register write (link) still commits.
- FLUSH state:
  - flush_o=1.
  - Every input cycle decrements the counter; no writes, jumps or end are accepted.
  - At 1 the state returns to RUN. If FLUSH_DEPTH=0, FLUSH is skipped.
- End:
  - flagEnd_i in RUN moves the state to HALT; halt_o=1 next cycle and stays set until reset.
  - In HALT all write enables and pc_sel_o are 0; inputs are ignored.
- Simultaneous jump and end: end wins, no redirect.
- flagEnd_i during FLUSH is squashed (wrong path).
- Reset mid-FLUSH or in HALT: state returns to RUN immediately and asynchronously; all outputs clear.
- States: RUN, FLUSH, HALT. 2-bit encoding; the unused code goes to RUN.

Optional Feature:
- WB_RETIRE_CNT_EN. When defined:
  - Adds output retired_cnt_o, REGI_SIZE bits, reset 0.
  - Increments by 1 on each cycle an instruction is live (including NOP-free jumps and non-writing instructions; excluding NOPs, squashed instructions and END).
  - Wraps from 16'hFFFF to 0 and freezes in HALT.
- When not defined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Release reset, present writeResultInt_i=1, intRegDest_i=4'd5, res_i=64'h0000_0000_0000_BEEF -> next cycle int_we_o=1, int_dest_o=5, int_wd_o=16'hBEEF; vec_we_o=0.
- writeResultV_i=1, vecRegDest_i=2'd2, res_i=64'h0102_0304_0506_0708, flagNop_i=1 -> vec_we_o stays 0. Repeat with flagNop_i=0 -> vec_we_o=1, vec_wd_o=64'h0102030405060708.
- enableJump_i=1, jumpAddress_i=10'h3A5, then 3 cycles with writeResultInt_i=1 -> pc_sel_o one-cycle pulse, redirect_pc_o=16'h03A5, flush_o high for 3 cycles, no int_we_o; 4th write commits.
- flagEnd_i=1 together with enableJump_i=1 -> halt_o=1, pc_sel_o=0. Subsequent writes are ignored for 10 cycles and halt_o stays 1.
- Jump, then assert rst_i=0 on the second FLUSH cycle -> flush_o, pc_sel_o, halt_o drop without waiting for a clock edge. After release the first write commits normally.
- With WB_RETIRE_CNT_EN: 5 live instructions, 2 NOPs, 1 END -> retired_cnt_o=5 and frozen afterwards.
